// File: rtl/mem_line_arbiter.sv
// Purpose: arbitrates the single word-wide memory port between ICache fills and DCache fills/write-backs, one full line burst at a time.
// Latency: grant at E0, one word per mem_ack, done pulse in the cycle after E_N, IDLE after E_{N+1}, next grant at E_{N+2} or later.
// Backpressure: mem_ack low stalls the burst indefinitely with all outputs held; requesters hold req until their done pulse.
module mem_line_arbiter #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int STARVE_LIMIT  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [31:0]              i_addr,
  output logic                     i_rvalid,
  output logic [31:0]              i_rdata,
  output logic                     i_done,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [31:0]              d_addr,
  input  logic [31:0]              d_wdata,
  output logic                     d_rvalid,
  output logic [31:0]              d_rdata,
  output logic                     d_done,
  output logic [LINE_ADDR_LEN-1:0] word_idx,
  output logic [1:0]               grant,
  output logic                     busy,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_ack,
  output logic [31:0]              i_cnt,
  output logic [31:0]              d_cnt
);

  localparam int BASE_W = 32 - LINE_ADDR_LEN - 2;
  localparam int STRK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [LINE_ADDR_LEN-1:0] LAST_IDX = {LINE_ADDR_LEN{1'b1}};
  localparam logic [STRK_W-1:0]        STRK_MAX = STRK_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [BASE_W-1:0] base;
  logic              we_q;
  logic [STRK_W-1:0] streak;
  logic              take_d;
  logic              take_i;

  // Byte/word offset bits of the request addresses carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[LINE_ADDR_LEN+1:0], d_addr[LINE_ADDR_LEN+1:0]};

  // Grant decision for IDLE: D wins ties unless I has already waited out STARVE_LIMIT D grants.
  always_comb begin
    take_d = d_req && !(i_req && (streak == STRK_MAX));
    take_i = i_req && !take_d;
  end

  // Main sequencer: IDLE -> BURST -> DONE -> IDLE, all control outputs registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      base     <= '0;
      we_q     <= 1'b0;
      streak   <= '0;
      grant    <= 2'b00;
      busy     <= 1'b0;
      mem_req  <= 1'b0;
      word_idx <= '0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      i_cnt    <= '0;
      d_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take_d) begin
            state    <= S_BURST;
            grant    <= 2'b10;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            base     <= d_addr[31:LINE_ADDR_LEN+2];
            we_q     <= d_we;
            word_idx <= '0;
            // Only D grants that beat a waiting I count toward starvation.
            streak   <= i_req ? streak + STRK_W'(1) : '0;
          end else if (take_i) begin
            state    <= S_BURST;
            grant    <= 2'b01;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            base     <= i_addr[31:LINE_ADDR_LEN+2];
            we_q     <= 1'b0;
            word_idx <= '0;
            streak   <= '0;
          end
        end
        S_BURST: begin
          if (mem_ack) begin
            if (word_idx == LAST_IDX) begin
              state    <= S_DONE;
              mem_req  <= 1'b0;
              word_idx <= '0;
              i_done   <= grant[0];
              d_done   <= grant[1];
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          grant  <= 2'b00;
          we_q   <= 1'b0;
          i_done <= 1'b0;
          d_done <= 1'b0;
          if (grant[0]) i_cnt <= i_cnt + 32'd1;
          if (grant[1]) d_cnt <= d_cnt + 32'd1;
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          grant    <= 2'b00;
          mem_req  <= 1'b0;
          i_done   <= 1'b0;
          d_done   <= 1'b0;
          word_idx <= '0;
        end
      endcase
    end
  end

  // Memory-side word request, driven only while a burst is active.
  always_comb begin
    mem_we    = mem_req & we_q;
    mem_addr  = mem_req ? {base, word_idx, 2'b00} : 32'd0;
    mem_wdata = (mem_req & we_q) ? d_wdata : 32'd0;
  end

  // Read data forwarded straight through to whichever cache owns the fill.
  always_comb begin
    i_rvalid = mem_req & mem_ack & ~we_q & grant[0];
    d_rvalid = mem_req & mem_ack & ~we_q & grant[1];
    i_rdata  = i_rvalid ? mem_rdata : 32'd0;
    d_rdata  = d_rvalid ? mem_rdata : 32'd0;
  end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Purpose: self-checking bench for mem_line_arbiter with a word scoreboard and a burst vector table.
// Latency: checks grant-to-done and back-to-back grant spacing with mem_ack held high.
// Backpressure: mem_ack is driven always-on, toggling, or off by a small memory model process.
module tb_mem_line_arbiter;
  localparam int LAL = 3;
  localparam int N   = 1 << LAL;

  logic           clk;
  logic           rst;
  logic           i_req;
  logic [31:0]    i_addr;
  logic           i_rvalid;
  logic [31:0]    i_rdata;
  logic           i_done;
  logic           d_req;
  logic           d_we;
  logic [31:0]    d_addr;
  logic [31:0]    d_wdata;
  logic           d_rvalid;
  logic [31:0]    d_rdata;
  logic           d_done;
  logic [LAL-1:0] word_idx;
  logic [1:0]     grant;
  logic           busy;
  logic           mem_req;
  logic           mem_we;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic [31:0]    mem_rdata;
  logic           mem_ack;
  logic [31:0]    i_cnt;
  logic [31:0]    d_cnt;

  logic [31:0]    wd_base;
  int             ack_mode;   // 0 = off, 1 = always on, 2 = toggle every cycle
  int             checks;
  int             errors;

  mem_line_arbiter #(.LINE_ADDR_LEN(LAL), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .word_idx(word_idx), .grant(grant), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .i_cnt(i_cnt), .d_cnt(d_cnt)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // DCache write-back source and memory read data models.
  assign d_wdata   = wd_base + 32'(word_idx);
  assign mem_rdata = mem_val(mem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       mem_ack = 1'b0;
        1:       mem_ack = 1'b1;
        default: mem_ack = ~mem_ack;
      endcase
    end
  end

  typedef struct {
    logic [31:0]    addr;
    logic           we;
    logic [31:0]    wdata;
    logic           i_rv;
    logic           d_rv;
    logic [31:0]    rdata;
    logic [LAL-1:0] idx;
  } word_t;

  word_t      word_q[$];
  logic [1:0] grant_q[$];
  logic [1:0] done_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(input logic is_d, input logic we, input logic [31:0] base,
                            input logic [31:0] wbase, input int nwords, input logic with_done);
    word_t w;
    for (int k = 0; k < nwords; k++) begin
      w.addr  = base + 32'(4 * k);
      w.we    = is_d & we;
      w.wdata = (is_d & we) ? wbase + 32'(k) : 32'd0;
      w.i_rv  = ~is_d;
      w.d_rv  = is_d & ~we;
      w.rdata = mem_val(w.addr);
      w.idx   = LAL'(k);
      word_q.push_back(w);
    end
    grant_q.push_back(is_d ? 2'b10 : 2'b01);
    if (with_done) done_q.push_back(is_d ? 2'b10 : 2'b01);
  endtask

  // Scoreboard monitor: pops expected words, grants and done pulses as the DUT produces them.
  initial begin
    logic [1:0] prev_g;
    word_t      w;
    logic [1:0] e;
    prev_g = 2'b00;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_ack === 1'b1) begin
        if (word_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_word: mem_addr=%h with no word expected", mem_addr);
        end else begin
          w = word_q.pop_front();
          chk("mem_addr", mem_addr, w.addr);
          chk("mem_we", 32'(mem_we), 32'(w.we));
          chk("mem_wdata", mem_wdata, w.wdata);
          chk("word_idx", 32'(word_idx), 32'(w.idx));
          chk("i_rvalid", 32'(i_rvalid), 32'(w.i_rv));
          chk("d_rvalid", 32'(d_rvalid), 32'(w.d_rv));
          chk("i_rdata", i_rdata, w.i_rv ? w.rdata : 32'd0);
          chk("d_rdata", d_rdata, w.d_rv ? w.rdata : 32'd0);
        end
      end
      if (mem_req !== 1'b1 && (i_rvalid === 1'b1 || d_rvalid === 1'b1)) begin
        checks++;
        errors++;
        $display("FAIL rvalid_outside_burst: i_rvalid=%b d_rvalid=%b", i_rvalid, d_rvalid);
      end
      if (prev_g == 2'b00 && grant != 2'b00) begin
        if (grant_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_grant: grant=%b with no grant expected", grant);
        end else begin
          e = grant_q.pop_front();
          chk("grant_order", 32'(grant), 32'(e));
        end
      end
      if (i_done === 1'b1 || d_done === 1'b1) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: i_done=%b d_done=%b", i_done, d_done);
        end else begin
          e = done_q.pop_front();
          chk("done_owner", 32'({d_done, i_done}), 32'(e));
          chk("done_grant", 32'(grant), 32'(e));
          chk("done_mem_req", 32'(mem_req), 32'd0);
        end
      end
      prev_g = grant;
    end
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wbase;
    int          mode;
    int          exp_lat;   // 0 = latency not fixed (stalling ack)
    logic [31:0] exp_base;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t;
    int nd;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0000_0000, 1, N, 32'h0000_1220, 32'd1, 32'd0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0080, 32'h0000_00A0, 2, 0, 32'h0000_0080, 32'd1, 32'd1};
    vecs[2] = '{1'b1, 1'b0, 32'hFFFF_FFE5, 32'h0000_0000, 1, N, 32'hFFFF_FFE0, 32'd1, 32'd2};
    vecs[3] = '{1'b0, 1'b1, 32'h4000_003F, 32'h0000_0000, 2, 0, 32'h4000_0020, 32'd2, 32'd2};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_1000, 32'h1111_0000, 1, N, 32'h0000_1000, 32'd2, 32'd3};

    checks = 0; errors = 0; ack_mode = 0;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; wd_base = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_word_idx", 32'(word_idx), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_dones", 32'({i_done, d_done}), 32'd0);
    chk("rst_i_cnt", i_cnt, 32'd0);
    chk("rst_d_cnt", d_cnt, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single-requester bursts from the vector table.
    for (int v = 0; v < 5; v++) begin
      ack_mode = vecs[v].mode;
      wd_base  = vecs[v].wbase;
      d_we     = vecs[v].we;
      push_burst(vecs[v].is_d, vecs[v].we, vecs[v].exp_base, vecs[v].wbase, N, 1'b1);
      if (vecs[v].is_d) begin d_addr = vecs[v].addr; d_req = 1'b1; end
      else begin i_addr = vecs[v].addr; i_req = 1'b1; end
      t = 0;
      while (grant == 2'b00 && t < 20) begin @(negedge clk); t++; end
      chk("vec_grant_seen", 32'(grant != 2'b00), 32'd1);
      t = 0;
      while (!(i_done || d_done) && t < 200) begin @(negedge clk); t++; end
      chk("vec_done_seen", 32'(i_done | d_done), 32'd1);
      if (vecs[v].exp_lat != 0) chk("vec_latency", 32'(t), 32'(vecs[v].exp_lat));
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      chk("vec_idle_busy", 32'(busy), 32'd0);
      chk("vec_idle_grant", 32'(grant), 32'd0);
      chk("vec_i_cnt", i_cnt, vecs[v].exp_i);
      chk("vec_d_cnt", d_cnt, vecs[v].exp_d);
    end

    // Both requesters held high: D, D, I, D, D, I.
    ack_mode = 1; d_we = 1'b0; i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
    push_burst(1'b1, 1'b0, 32'h200, 32'h0, N, 1'b1);
    push_burst(1'b1, 1'b0, 32'h200, 32'h0, N, 1'b1);
    push_burst(1'b0, 1'b0, 32'h100, 32'h0, N, 1'b1);
    push_burst(1'b1, 1'b0, 32'h200, 32'h0, N, 1'b1);
    push_burst(1'b1, 1'b0, 32'h200, 32'h0, N, 1'b1);
    push_burst(1'b0, 1'b0, 32'h100, 32'h0, N, 1'b1);
    i_req = 1'b1; d_req = 1'b1;
    nd = 0; t = 0;
    while (nd < 6 && t < 400) begin
      @(negedge clk); t++;
      if (i_done || d_done) begin
        nd++;
        if (nd == 6) begin i_req = 1'b0; d_req = 1'b0; end
      end
    end
    chk("starve_bursts", 32'(nd), 32'd6);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("starve_i_cnt", i_cnt, 32'd4);
    chk("starve_d_cnt", d_cnt, 32'd7);

    // Simultaneous single-shot requests: D first, I granted N+2 edges later.
    d_addr = 32'h0000_0300; i_addr = 32'h0000_0400;
    push_burst(1'b1, 1'b0, 32'h300, 32'h0, N, 1'b1);
    push_burst(1'b0, 1'b0, 32'h400, 32'h0, N, 1'b1);
    i_req = 1'b1; d_req = 1'b1;
    t = 0;
    while (grant == 2'b00 && t < 20) begin @(negedge clk); t++; end
    chk("simul_first", 32'(grant), 32'b10);
    t = 0;
    while (grant != 2'b01 && t < 100) begin
      @(negedge clk); t++;
      if (d_done) d_req = 1'b0;
    end
    chk("simul_i_delay", 32'(t), 32'(N + 2));
    t = 0;
    while (!i_done && t < 100) begin @(negedge clk); t++; end
    i_req = 1'b0;
    @(negedge clk);
    chk("simul_i_cnt", i_cnt, 32'd5);
    chk("simul_d_cnt", d_cnt, 32'd8);

    // Reset in the middle of an I burst at word 3.
    i_addr = 32'h0000_2000;
    push_burst(1'b0, 1'b0, 32'h2000, 32'h0, 4, 1'b0);
    i_req = 1'b1;
    t = 0;
    while (!(mem_req && word_idx == 3) && t < 50) begin @(negedge clk); t++; end
    chk("mid_word3_seen", 32'(word_idx), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_mem_req", 32'(mem_req), 32'd0);
    chk("mid_grant", 32'(grant), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_i_done", 32'(i_done), 32'd0);
    chk("mid_i_cnt", i_cnt, 32'd0);
    chk("mid_d_cnt", d_cnt, 32'd0);
    push_burst(1'b0, 1'b0, 32'h2000, 32'h0, N, 1'b1);
    rst = 1'b0;
    t = 0;
    while (!i_done && t < 100) begin @(negedge clk); t++; end
    chk("restart_done", 32'(i_done), 32'd1);
    i_req = 1'b0;
    @(negedge clk);
    chk("restart_i_cnt", i_cnt, 32'd1);
    chk("restart_d_cnt", d_cnt, 32'd0);

    // mem_ack pulsing while IDLE must not move anything.
    ack_mode = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_ack_busy", 32'(busy), 32'd0);
      chk("idle_ack_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
      chk("idle_ack_word_idx", 32'(word_idx), 32'd0);
      chk("idle_ack_mem_req", 32'(mem_req), 32'd0);
    end
    ack_mode = 0;
    @(negedge clk);

    chk("word_q_empty", 32'(word_q.size()), 32'd0);
    chk("grant_q_empty", 32'(grant_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Shares the single word-wide main-memory port between the instruction cache (line fill, read-only) and the data cache (line fill or line write-back).
- Grants one requester at a time, sequences a full-line burst of 2^LINE_ADDR_LEN words, streams data to or from the granted cache, and signals completion.
- Sits between the ICache/DCache miss logic and the main-memory model.
- Keeps per-requester transfer counters for miss-traffic profiling.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line; burst length N = 2^LINE_ADDR_LEN.
- STARVE_LIMIT, 2, maximum consecutive D grants while I is pending; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  ICache line-fill request; held until i_done.
- i_addr  in  32  ICache line address; low LINE_ADDR_LEN+2 bits ignored.
- i_rvalid  out  1  fill word valid this cycle.
- i_rdata  out  32  fill word.
- i_done  out  1  one-cycle I completion pulse.
- d_req  in  1  DCache request; held until d_done.
- d_we  in  1  1 = write-back, 0 = fill; sampled at grant.
- d_addr  in  32  DCache line address; low LINE_ADDR_LEN+2 bits ignored.
- d_wdata  in  32  write-back word for the current word_idx; combinational from word_idx.
- d_rvalid  out  1  fill word valid this cycle.
- d_rdata  out  32  fill word.
- d_done  out  1  one-cycle D completion pulse.
- word_idx  out  LINE_ADDR_LEN  current word index within the burst.
- grant  out  2  01 = I owns the port, 10 = D owns it, 00 = idle.
- busy  out  1  state ≠ IDLE.
- mem_req  out  1  word request to memory.
- mem_we  out  1  word write enable.
- mem_addr  out  32  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  word accepted/returned; sampled at the rising edge while mem_req = 1.
- i_cnt  out  32  completed I bursts.
- d_cnt  out  32  completed D bursts.

Behaviour:
- Reset values:
  - State is IDLE.
  - All outputs are 0: grant, busy, word_idx, mem_*, *_rvalid, *_done, streak counter, i_cnt, d_cnt.
- Reset mid-burst: the next cycle is IDLE with mem_req = 0. No done pulse is issued, and the partial burst is abandoned.
- FSM states: IDLE, BURST, DONE.
- IDLE, at a rising edge, evaluates the requests in this order:
  - Only d_req = 1: grant D.
  - Only i_req = 1: grant I.
  - Both = 1: grant D, unless the streak counter equals STARVE_LIMIT, in which case grant I.
  - On grant: latch the line base (addr[31:LINE_ADDR_LEN+2]), latch d_we (forced 0 for I), set word_idx = 0, go to BURST.
- Streak counter:
  - Increments on a D grant made while i_req = 1.
  - Clears on any I grant.
  - Clears on a D grant made while i_req = 0.
- BURST state:
  - mem_req = 1.
  - mem_addr = {base, word_idx, 2'b00}.
  - mem_we = the latched d_we.
  - mem_wdata = d_wdata when a write-back is granted, else 0.
  - On a rising edge with mem_ack = 1, word_idx increments. When word_idx = N−1, go to DONE instead and return word_idx to 0.
  - mem_ack = 0 means wait indefinitely; all outputs are held.
- Read-data forwarding (combinational, BURST only):
  - x_rvalid = mem_ack & ~mem_we & (grant selects x).
  - x_rdata = mem_rdata when x_rvalid = 1, else 0.
- DONE state:
  - mem_req = 0.
  - The granted x_done = 1 for exactly one cycle.
  - The matching counter increments at the end-of-DONE edge, wrapping modulo 2^32.
  - grant holds its value through DONE, then goes to IDLE.
- Requester rule: x_req must be low at the edge ending DONE. A req still high in IDLE is treated as a new request.
- Latency with mem_ack tied to 1:
  - Grant at edge E0.
  - done high in the cycle after E_N.
  - IDLE after E_{N+1}.
  - Next grant no earlier than E_{N+2}.
- Ignored inputs:
  - mem_ack outside BURST.
  - Request address/we changes after grant.

Test Plan:
- Reset, then i_req = 1, i_addr = 0x0000_1234, mem_ack = 1 → mem_addr steps 0x1220, 0x1224 … 0x123C over 8 cycles, i_rvalid on each, i_done after E8, i_cnt = 1.
- D write-back, d_addr = 0x80, d_wdata = 0xA0+word_idx, mem_ack toggled 1/0 → mem_we = 1, 8 words written 0xA0..0xA7 to 0x80..0x9C, stalls hold word_idx, d_rvalid never 1, d_done once, d_cnt = 1.
- i_req and d_req held high continuously, STARVE_LIMIT = 2 → grant order D, D, I, D, D, I; i_cnt = 2, d_cnt = 4 after 6 bursts.
- Simultaneous single-shot requests → D granted first, I granted at E_{N+2} after the D grant.
- rst asserted at word_idx = 3 of an I burst → next cycle mem_req = 0, grant = 0, no i_done, i_cnt = 0; a new request then starts at word 0.
- mem_ack pulsed while IDLE → no state change, no rvalid.
